uart_tx_writer: RTL
===================

// Module: uart_tx_writer
// PURPOSE
//  Serial bit-stream writer: the transmit end of the 8N1 serial link whose receive end samples i_in.
//  Accepts a parallel word through a valid/ready handshake. Shifts it out LSB-first on o_tx as start bit, data bits, stop bit.
//  Sits between the signal generators / control FSMs and the board serial pin.
//  Also drives the stimulus line for serial-reader benches.
// PARAMETERS
//  CLKS_PER_BIT  868  i_clk cycles per serial bit (100 MHz / 115200); legal range >= 2
//  DATA_BITS     8    payload bits per frame; legal range 5..9
// PORTS
//  i_clk    in   1          system clock; all logic on rising edge
//  i_reset  in   1          synchronous, active-high reset
//  i_data   in   DATA_BITS  word to send; sampled only on handshake
//  i_valid  in   1          producer has a word on i_data
//  o_ready  out  1          block can accept a word this cycle
//  o_tx     out  1          serial line; idles high
//  o_busy   out  1          frame in progress (any state except IDLE)
//  o_done   out  1          one-cycle pulse on the last cycle of the stop bit
// BEHAVIOUR
//  Clock and reset
//   - One clock domain (i_clk).
//   - Reset is synchronous and active-high on i_reset; no async paths.
//  Reset values (cycle after i_reset=1)
//   - State IDLE; o_tx=1, o_ready=1, o_busy=0, o_done=0.
//   - Bit counter and cycle counter = 0.
//  FSM states: IDLE -> START -> DATA -> STOP -> IDLE
//   - IDLE
//     - o_ready=1, o_tx=1.
//     - Handshake = i_valid & o_ready at a rising edge.
//     - On handshake: latch i_data into the shift register and go to START.
//   - START
//     - o_tx=0 for exactly CLKS_PER_BIT cycles.
//     - First START cycle is the cycle after the handshake.
//   - DATA
//     - o_tx = shift_reg[0] for CLKS_PER_BIT cycles per bit; LSB first.
//     - Shift right after each bit.
//     - Leave after DATA_BITS bits.
//   - STOP
//     - o_tx=1 for CLKS_PER_BIT cycles.
//     - o_done=1 on the final STOP cycle.
//     - Next state IDLE.
//  Timing
//   - Frame length is exactly (DATA_BITS+2)*CLKS_PER_BIT cycles from the first START cycle.
//   - o_tx is registered and glitch-free.
//  Handshake rules
//   - o_ready=0 whenever o_busy=1.
//   - i_valid while busy is ignored; the producer must hold it until a handshake occurs.
//   - i_data changes during a frame do not affect the frame.
//  Back-to-back frames
//   - With i_valid held high, the next handshake happens in the first IDLE cycle after o_done.
//   - This gives exactly 1 extra idle-high cycle between stop bit and next start bit.
//  Counters and widths
//   - Cycle counter width = $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then wraps to 0.
//   - Bit counter width = $clog2(DATA_BITS+1).
//  Reset mid-frame
//   - Frame is aborted; the next cycle follows the reset values above (o_tx=1).
//   - No o_done pulse; the partial frame is not resumed.
//  Reset and i_valid in the same cycle: reset wins; no handshake.
// TESTING (bench uses CLKS_PER_BIT=4, DATA_BITS=8)
//  1. Reset
//     - Stimulus: hold i_reset 3 cycles with i_valid=1.
//     - Response: o_tx=1, o_ready=1, o_busy=0, o_done=0; no frame starts.
//  2. Single frame
//     - Stimulus: i_data=8'hA5 with a one-cycle valid pulse.
//     - Response: o_tx = 0, then 1,0,1,0,0,1,0,1, then 1; each level held 4 cycles.
//     - o_done pulses at cycle 40; o_ready=1 at cycle 41.
//  3. Back-to-back frames
//     - Stimulus: i_valid held high with 8'h00 then 8'hFF.
//     - Response: exactly 1 idle-high cycle between the frames; both frames decode correctly.
//  4. Busy ignore
//     - Stimulus: drive i_valid=1 with i_data=8'h3C mid-frame of 8'h81.
//     - Response: 8'h81 is sent intact; 8'h3C is sent only after o_ready returns.
//  5. Reset mid-frame
//     - Stimulus: assert i_reset during data bit 3.
//     - Response: o_tx=1 the next cycle, no o_done; a new frame afterwards is correct.
//  6. Loopback
//     - Stimulus: feed o_tx into the serial reader; send 16 random words.
//     - Response: the verifier sees all 16 words in order.

Source files
------------

// File: rtl/uart_tx_writer.sv
// 8N1 serial transmitter: word accepted on i_valid & o_ready, first start-bit cycle follows the handshake, frame lasts (DATA_BITS+2)*CLKS_PER_BIT cycles.
// Backpressure: o_ready is low for the whole frame; i_valid seen while busy is ignored until the block returns to idle.
module uart_tx_writer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          shift_d = i_data;
          state_d = START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // done is registered, so raise it one cycle early to land on the last stop cycle
          done_d = (cnt_q == CNT_PEN);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule
